// File: rtl/camera_reg_sequencer_pkg.sv
// Shared definitions for the camera register sequencer.
//   state_e       : sequencer FSM states (verify states only reached when
//                   CAM_SEQ_VERIFY_EN is defined)
//   END_MARKER    : table sub-address value that terminates the table
//   I2C_WRITE/READ: values of the rw bit, also the LSB of the bus address
package cam_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_CHECK,
        ST_GAP,
        ST_DONE,
        ST_ERROR,
        ST_VERIFY_ISSUE,
        ST_VERIFY_WAIT_BUSY,
        ST_VERIFY_WAIT_DONE
    } state_e;

    localparam logic [7:0] END_MARKER = 8'hFF;
    localparam logic       I2C_WRITE  = 1'b0;
    localparam logic       I2C_READ   = 1'b1;

    // Bus address for a transfer: device address with the rw bit OR-ed in.
    function automatic logic [7:0] bus_addr(input logic [7:0] dev, input logic rw);
        return dev | {7'd0, rw};
    endfunction

endpackage

// File: rtl/camera_reg_sequencer_if.sv
// Request/response bundle between the sequencer and an I2C byte master.
//   ena      : transaction request (sequencer -> master)
//   rw       : 0 = write, 1 = read
//   addr     : device bus address
//   sub_addr : register address
//   data_wr  : write data
//   data_rd  : read data (master -> sequencer)
//   busy     : master busy
//   ack_err  : NACK flag, valid when busy falls
interface camera_reg_sequencer_if;

    logic       ena;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] sub_addr;
    logic [7:0] data_wr;
    logic [7:0] data_rd;
    logic       busy;
    logic       ack_err;

    modport master (
        output ena, rw, addr, sub_addr, data_wr,
        input  data_rd, busy, ack_err
    );

    modport slave (
        input  ena, rw, addr, sub_addr, data_wr,
        output data_rd, busy, ack_err
    );

endinterface

// File: rtl/camera_reg_sequencer_gap_timer.sv
// cam_gap_timer: down-counter used for the idle gap between table entries.
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset (counter cleared)
//   load    : reload the counter with GAP_CYCLES
//   expired : high while the counter is zero
module cam_gap_timer #(
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    // A zero-length gap still needs a one-bit counter.
    localparam int unsigned CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb expired = (cnt_q == '0);

endmodule

// File: rtl/camera_reg_sequencer.sv
// camera_reg_sequencer: walks a register table and writes each entry to a
// camera sensor through an I2C byte master, with per-entry retry and an idle
// gap after every successful entry.
//   clk, rst      : clock and synchronous active-low reset
//   start         : one-cycle pulse, accepted in IDLE/DONE/ERROR
//   tbl_idx       : table read index
//   tbl_sub_addr  : table register address (valid one cycle after tbl_idx)
//   tbl_data      : table register value  (valid one cycle after tbl_idx)
//   i2c           : master side of camera_reg_sequencer_if
//   done / error  : sticky completion / abort flags, cleared by start
//   err_idx       : index of the entry that exhausted its retries
// Build option: define CAM_SEQ_VERIFY_EN to read back every write and treat a
// NACK or data mismatch on the read as a failed attempt.
module camera_reg_sequencer
    import cam_pkg::*;
#(
    parameter logic [7:0]  DEV_ADDR   = 8'h42,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned GAP_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [7:0]                    tbl_idx,
    input  logic [7:0]                    tbl_sub_addr,
    input  logic [7:0]                    tbl_data,
    camera_reg_sequencer_if.master        i2c,
    output logic                          done,
    output logic                          error,
    output logic [7:0]                    err_idx
);

    localparam logic [7:0] LAST_IDX  = 8'(NUM_REGS - 1);
    localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

    state_e     state_q,     state_d;
    logic [7:0] tbl_idx_q,   tbl_idx_d;
    logic [3:0] retry_q,     retry_d;
    logic       ena_q,       ena_d;
    logic       rw_q,        rw_d;
    logic [7:0] addr_q,      addr_d;
    logic [7:0] sub_addr_q,  sub_addr_d;
    logic [7:0] data_wr_q,   data_wr_d;
    logic       done_q,      done_d;
    logic       error_q,     error_d;
    logic [7:0] err_idx_q,   err_idx_d;
    logic       fail_q,      fail_d;
    logic       gap_load;
    logic       gap_expired;

    cam_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap (
        .clk    (clk),
        .rst    (rst),
        .load   (gap_load),
        .expired(gap_expired)
    );

    always_comb begin
        state_d    = state_q;
        tbl_idx_d  = tbl_idx_q;
        retry_d    = retry_q;
        ena_d      = ena_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        sub_addr_d = sub_addr_q;
        data_wr_d  = data_wr_q;
        done_d     = done_q;
        error_d    = error_q;
        err_idx_d  = err_idx_q;
        fail_d     = fail_q;
        gap_load   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    tbl_idx_d = '0;
                    retry_d   = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_idx_d = '0;
                end
            end

            // Table data lags tbl_idx by a cycle, so it is first usable in ISSUE.
            ST_FETCH: state_d = ST_ISSUE;

            // End marker is examined here, the first cycle the entry is valid;
            // retries of the same entry come back through this check harmlessly.
            ST_ISSUE: begin
                if (tbl_sub_addr == END_MARKER) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else if (!i2c.busy) begin
                    sub_addr_d = tbl_sub_addr;
                    data_wr_d  = tbl_data;
                    rw_d       = I2C_WRITE;
                    addr_d     = bus_addr(DEV_ADDR, I2C_WRITE);
                    ena_d      = 1'b1;
                    state_d    = ST_WAIT_BUSY;
                end
            end

            ST_WAIT_BUSY: begin
                if (i2c.busy) begin
                    ena_d   = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                if (!i2c.busy) begin
                    fail_d  = i2c.ack_err;
                    state_d = ST_CHECK;
                end
            end

            // Retry count is cleared only once the whole entry (write and,
            // when enabled, read-back) has succeeded.
            ST_CHECK: begin
                if (fail_q) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ST_ISSUE;
                    end else begin
                        err_idx_d = tbl_idx_q;
                        error_d   = 1'b1;
                        state_d   = ST_ERROR;
                    end
`ifdef CAM_SEQ_VERIFY_EN
                end else if (rw_q == I2C_WRITE) begin
                    state_d = ST_VERIFY_ISSUE;
`endif
                end else begin
                    retry_d  = '0;
                    gap_load = 1'b1;
                    state_d  = ST_GAP;
                end
            end

            ST_GAP: begin
                if (gap_expired) begin
                    if (tbl_idx_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        tbl_idx_d = tbl_idx_q + 8'd1;
                        state_d   = ST_FETCH;
                    end
                end
            end

`ifdef CAM_SEQ_VERIFY_EN
            ST_VERIFY_ISSUE: begin
                if (!i2c.busy) begin
                    rw_d    = I2C_READ;
                    addr_d  = bus_addr(DEV_ADDR, I2C_READ);
                    ena_d   = 1'b1;
                    state_d = ST_VERIFY_WAIT_BUSY;
                end
            end

            ST_VERIFY_WAIT_BUSY: begin
                if (i2c.busy) begin
                    ena_d   = 1'b0;
                    state_d = ST_VERIFY_WAIT_DONE;
                end
            end

            ST_VERIFY_WAIT_DONE: begin
                if (!i2c.busy) begin
                    fail_d  = i2c.ack_err | (i2c.data_rd != data_wr_q);
                    state_d = ST_CHECK;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tbl_idx_q  <= '0;
            retry_q    <= '0;
            ena_q      <= 1'b0;
            rw_q       <= I2C_WRITE;
            addr_q     <= DEV_ADDR;
            sub_addr_q <= '0;
            data_wr_q  <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_idx_q  <= '0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tbl_idx_q  <= tbl_idx_d;
            retry_q    <= retry_d;
            ena_q      <= ena_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            sub_addr_q <= sub_addr_d;
            data_wr_q  <= data_wr_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_idx_q  <= err_idx_d;
            fail_q     <= fail_d;
        end
    end

    assign tbl_idx      = tbl_idx_q;
    assign i2c.ena      = ena_q;
    assign i2c.rw       = rw_q;
    assign i2c.addr     = addr_q;
    assign i2c.sub_addr = sub_addr_q;
    assign i2c.data_wr  = data_wr_q;
    assign done         = done_q;
    assign error        = error_q;
    assign err_idx      = err_idx_q;

endmodule
